// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment display controller: snapshots NUM_VALUES bytes,
// converts them one at a time with a shared shift-add-3 BCD engine into a
// display buffer, and scans the buffered digits onto one segment bus.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   values, update    packed input bytes and snapshot/reconvert request
//   blank_mask        live per-value blanking (both digits of value k)
//   anode, seg        active-low digit enables and segments {g..a}
//   digit_idx         digit being scanned
//   busy, conv_done   conversion in progress / buffer-updated pulse
module display_scan_controller #(
    parameter int NUM_VALUES  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_VALUES-1:0] values,
    input  logic                    update,
    input  logic [NUM_VALUES-1:0]   blank_mask,
    output logic [2*NUM_VALUES-1:0] anode,
    output logic [6:0]              seg,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    busy,
    output logic                    conv_done
);
    localparam int ND = 2 * NUM_VALUES;
    localparam int KW = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [8*NUM_VALUES-1:0] snap_q, snap_d;
    logic [KW-1:0]           k_q, k_d;
    logic [19:0]             sr_q, sr_d;
    logic [2:0]              bit_q, bit_d;
    logic                    store_en;

    logic [NUM_VALUES-1:0]   valid_q;
    logic [NUM_VALUES-1:0]   ovf_q;
    logic [3:0]              ones_q [NUM_VALUES];
    logic [3:0]              tens_q [NUM_VALUES];

    logic [PW-1:0]           presc_q, presc_d;
    logic [IDX_W-1:0]        dig_q, dig_d;
    logic [ND-1:0]           anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;

    // sr layout: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary.
    // The binary byte shifts into the BCD field one MSB per step.
    function automatic logic [19:0] bcd_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int n = 0; n < 3; n++) begin
            if (a[8+4*n +: 4] >= 4'd5) begin
                a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        k_d       = k_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        store_en  = 1'b0;
        busy      = 1'b0;
        conv_done = 1'b0;
        // Requests arriving outside IDLE coalesce into one restart.
        if (update && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (update || pending_q) begin
                    snap_d    = values;
                    pending_d = 1'b0;
                    k_d       = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                sr_d    = {12'b0, snap_q[8*k_q +: 8]};
                bit_d   = 3'd7;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy  = 1'b1;
                sr_d  = bcd_step(sr_q);
                bit_d = bit_q - 3'd1;
                if (bit_q == 3'd0) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                busy     = 1'b1;
                store_en = 1'b1;
                if (k_q == KW'(NUM_VALUES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                conv_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        dig_d   = dig_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            dig_d   = (dig_q == IDX_W'(ND - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    // Even digit = ones, odd digit = tens of value dig/2.
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_OFF;
        for (int k = 0; k < NUM_VALUES; k++) begin
            if ((dig_q >> 1) == IDX_W'(k) && valid_q[k] && !blank_mask[k]) begin
                anode_d = ~(ND'(1) << dig_q);
                if (ovf_q[k]) begin
                    seg_d = SEG_DASH;
                end else begin
                    seg_d = glyph(dig_q[0] ? tens_q[k] : ones_q[k]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            snap_q    <= '0;
            k_q       <= '0;
            sr_q      <= '0;
            bit_q     <= '0;
            valid_q   <= '0;
            ovf_q     <= '0;
            presc_q   <= '0;
            dig_q     <= '0;
            anode_q   <= '1;
            seg_q     <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            k_q       <= k_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            if (store_en) begin
                valid_q[k_q] <= 1'b1;
                ovf_q[k_q]   <= |sr_q[19:16];
            end
        end
    end

    // Digit data is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            ones_q[k_q] <= sr_q[11:8];
            tens_q[k_q] <= sr_q[15:12];
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign digit_idx = dig_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller (NUM_VALUES=2, REFRESH_DIV=4):
// cycle-level reference model plus directed literal scenarios.
module tb_display_scan_controller;
    localparam int NV  = 2;
    localparam int DIV = 4;
    localparam int IW  = 2;
    localparam int ND  = 4;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        update = 1'b0;
    logic [15:0] values = '0;
    logic [1:0]  blank_mask = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        busy;
    logic        conv_done;

    int total = 0;
    int bad = 0;

    logic [6:0] sevseg [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_VALUES (NV),
        .REFRESH_DIV(DIV),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .values    (values),
        .update    (update),
        .blank_mask(blank_mask),
        .anode     (anode),
        .seg       (seg),
        .digit_idx (digit_idx),
        .busy      (busy),
        .conv_done (conv_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a conversion is a timeline of cycles t=1..10*NV+1
    // after the snapshot edge; value k lands in the buffer at the end of
    // cycle 10*(k+1), done shows at t=10*NV+1.
    bit         m_run = 0;
    int         m_t = 0;
    bit         m_pend = 0;
    logic [7:0] m_snap [NV];
    bit         m_valid [NV];
    logic [7:0] m_val [NV];
    int         m_presc = 0;
    int         m_dig = 0;
    logic [3:0] e_anode = 4'hf;
    logic [6:0] e_seg = OFF;

    // Inputs here are the ones sampled at the posedge just passed.
    always @(negedge clk) begin
        int k;
        if (rst) begin
            m_run = 0;
            m_t = 0;
            m_pend = 0;
            m_presc = 0;
            m_dig = 0;
            for (int i = 0; i < NV; i++) begin
                m_valid[i] = 0;
                m_val[i] = '0;
            end
            e_anode = 4'hf;
            e_seg = OFF;
        end else begin
            e_anode = 4'hf;
            e_seg = OFF;
            k = m_dig / 2;
            if (m_valid[k] && !blank_mask[k]) begin
                e_anode[m_dig] = 1'b0;
                if (m_val[k] > 99) e_seg = DASH;
                else if (m_dig % 2 == 1) e_seg = sevseg[m_val[k] / 10];
                else e_seg = sevseg[m_val[k] % 10];
            end
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_dig = (m_dig + 1) % ND;
            end else begin
                m_presc++;
            end
            if (m_run) begin
                if (update) m_pend = 1;
                if (m_t % 10 == 0 && m_t >= 10 && m_t <= 10 * NV) begin
                    m_valid[m_t/10-1] = 1;
                    m_val[m_t/10-1] = m_snap[m_t/10-1];
                end
                if (m_t == 10 * NV + 1) m_run = 0;
                else m_t++;
            end else if (update || m_pend) begin
                for (int i = 0; i < NV; i++) m_snap[i] = values[8*i +: 8];
                m_pend = 0;
                m_run = 1;
                m_t = 1;
            end
        end
        chk("cmp_anode", anode, e_anode);
        chk("cmp_seg", seg, e_seg);
        chk("cmp_digit", digit_idx, m_dig);
        chk("cmp_busy", busy, m_run && m_t <= 10 * NV);
        chk("cmp_done", conv_done, m_run && m_t == 10 * NV + 1);
    end

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit && conv_done !== 1'b1) begin
            tick();
            n++;
        end
        chk("done_seen", conv_done, 1'b1);
    endtask

    // Sync to digit 3, then walk digits 0..3 checking glyph and dwell.
    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        logic [3:0] ea;
        int w;
        int run;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        w = 0;
        while (anode !== 4'b0111 && w < 40) begin
            tick();
            w++;
        end
        chk("scan_sync", w < 40, 1'b1);
        w = 0;
        while (anode === 4'b0111 && w < 10) begin
            tick();
            w++;
        end
        for (int d = 0; d < 4; d++) begin
            ea = ~(4'b0001 << d);
            chk("scan_anode", anode, ea);
            chk("scan_seg", seg, s[d]);
            run = 0;
            while (anode === ea && run < 10) begin
                run++;
                tick();
            end
            chk("scan_dwell", run, 4);
        end
    endtask

    initial begin
        int n;
        int dones;
        int second;
        bit ok;
        bit ok2;
        bit seen;

        repeat (3) tick();
        chk("rst_anode", anode, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        ok = 1;
        repeat (20) begin
            tick();
            if (anode !== 4'b1111) ok = 0;
        end
        chk("idle_dark", ok, 1'b1);

        values = {8'd97, 8'd42};
        update = 1'b1;
        tick();
        update = 1'b0;
        chk("busy_next", busy, 1'b1);
        n = 1;
        while (n < 40 && conv_done !== 1'b1) begin
            tick();
            n++;
        end
        chk("done_latency", n, 21);
        scan4(7'b0100100, 7'b0011001, 7'b1111000, 7'b0010000);

        values = {8'd0, 8'd200};
        update = 1'b1;
        tick();
        update = 1'b0;
        wait_done(40, n);
        scan4(DASH, DASH, 7'b1000000, 7'b1000000);

        values = {8'd13, 8'd42};
        update = 1'b1;
        tick();
        update = 1'b0;
        dones = 0;
        second = 0;
        for (n = 1; n <= 80; n++) begin
            if (conv_done === 1'b1) begin
                dones++;
                if (dones == 2) second = n;
            end
            if (n == 5) update = 1'b1;
            if (n == 6) begin
                update = 1'b0;
                values = {8'd13, 8'd99};
            end
            tick();
        end
        chk("pend_dones", dones, 2);
        chk("pend_second_at", second, 43);
        scan4(7'b0010000, 7'b0010000, 7'b0110000, 7'b1111001);

        blank_mask = 2'b10;
        tick();
        ok = 1;
        seen = 0;
        repeat (16) begin
            if (anode[3:2] !== 2'b11) ok = 0;
            if (anode === 4'b1110) seen = 1;
            tick();
        end
        chk("blank_hi", ok, 1'b1);
        chk("blank_lo_scan", seen, 1'b1);
        blank_mask = 2'b00;
        scan4(7'b0010000, 7'b0010000, 7'b0110000, 7'b1111001);
        chk("no_reconv", busy, 1'b0);

        values = {8'd77, 8'd33};
        update = 1'b1;
        tick();
        update = 1'b0;
        for (n = 1; n < 12; n++) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", conv_done, 1'b0);
        rst = 1'b0;
        ok = 1;
        ok2 = 1;
        repeat (40) begin
            tick();
            if (anode !== 4'b1111) ok = 0;
            if (conv_done !== 1'b0) ok2 = 0;
        end
        chk("abort_dark", ok, 1'b1);
        chk("abort_nodone", ok2, 1'b1);
        values = {8'd150, 8'd5};
        update = 1'b1;
        tick();
        update = 1'b0;
        wait_done(40, n);
        scan4(7'b0010010, 7'b1000000, DASH, DASH);

        for (int i = 0; i < 400; i++) begin
            update = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) values = 16'($urandom);
            if ($urandom_range(0, 31) == 0) blank_mask = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        update = 1'b0;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Drives the board's multiplexed 7-segment display from NUM_VALUES 8-bit datapath values, such as PC low byte or register readouts.
- Contains one shared, sequential binary-to-BCD (shift-add-3) engine that converts the snapshotted values one at a time into a display buffer.
- A refresh scanner time-multiplexes the buffered digits onto a single active-low segment bus with active-low anodes.

Parameters:
- NUM_VALUES, 4: number of 8-bit values displayed; 2 digits each, so 2*NUM_VALUES digits.
- REFRESH_DIV, 50000: clk cycles each digit stays lit; must be >= 1.
- IDX_W, 3: width of digit_idx; must satisfy 2^IDX_W >= 2*NUM_VALUES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- values  in  8*NUM_VALUES  packed values; value k = values[8k+7:8k].
- update  in  1  request to snapshot values and reconvert.
- blank_mask  in  NUM_VALUES  bit k=1 blanks both digits of value k; applied live, not snapshotted.
- anode  out  2*NUM_VALUES  active-low digit enables; at most one bit low.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- digit_idx  out  IDX_W  digit currently being scanned.
- busy  out  1  conversion in progress.
- conv_done  out  1  one-cycle pulse when the buffer is fully updated.

Behaviour:
- Interface: one clock domain (clk). Reset rst is synchronous and active-high.
- Reset values: anode all 1, seg 7'b1111111, digit_idx 0, busy 0, conv_done 0, prescaler 0.
- Reset state: FSM IDLE, pending 0, all buffer entries marked invalid.
- Reset mid-conversion aborts the conversion; the display buffer is invalidated.
- Conversion FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
  - IDLE: if update=1 or pending=1, snapshot all values, clear pending, set k=0, go to LOAD. busy=1 from the next cycle.
  - LOAD (1 cycle): shift register = {12'b0, value k}; bit counter = 7.
  - SHIFT (8 cycles): each cycle, add 3 to any BCD nibble >= 5, then shift left 1 and bring in the next MSB of value k.
  - STORE (1 cycle): write ones, tens and ovf to buffer entry k, and mark it valid. ovf=1 when the hundreds nibble != 0, i.e. value > 99. If k < NUM_VALUES-1, increment k and go to LOAD; otherwise go to DONE.
  - DONE (1 cycle): conv_done=1, busy=0 in this cycle, then go to IDLE.
- Latency: 10 cycles per value, so conv_done asserts 10*NUM_VALUES+1 cycles after the update edge.
- update while busy: sets pending; exactly one reconversion follows DONE. Extra requests coalesce, and the new snapshot is taken at that restart.
- Buffer writes are per entry; the scanner may show a mix of old and new entries during a conversion (accepted).
- Scanner runs independently of the FSM.
  - Prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and digit_idx advances, wrapping from 2*NUM_VALUES-1 to 0.
  - anode and seg are registered and follow digit_idx by 1 cycle.
- Digit mapping: digit 2k shows ones of value k; digit 2k+1 shows tens of value k.
- Digit display rules, in priority order:
  1. Entry invalid or blank_mask[k]=1: anode bit high, seg 7'b1111111.
  2. ovf=1: anode low, seg 7'b0111111 (dash) on both digits.
  3. Otherwise: anode low, seg = decimal glyph.
- Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Test Plan:
- Setup for all scenarios: NUM_VALUES=2, REFRESH_DIV=4.
- Reset: hold rst 3 cycles -> anode=4'b1111, seg=7'b1111111, busy=0; running 20 cycles with no update -> all digits stay dark.
- values={8'd97, 8'd42}, update pulse -> busy high next cycle; conv_done at cycle 21; then scan cycles digits 0..3 with seg 0100100 (2), 0011001 (4), 1111000 (7), 0010000 (9), each lit 4 cycles with the matching single anode low.
- values={8'd0, 8'd200}, update -> value 0 shows dashes (0111111) on digits 0 and 1; value 1 shows 1000000 on digits 2 and 3.
- update at cycle 5 of a conversion, with values changed to 8'd99 at cycle 6 -> exactly one extra 20-cycle pass after the first conv_done; final buffer shows 9,9 for the changed value; only 2 conv_done pulses total.
- blank_mask=2'b10 after a conversion -> anode[3:2] stay high; digits 0 and 1 still scan. Clearing the mask restores digits 2 and 3 with no reconversion.
- rst asserted at cycle 12 of a conversion -> next cycle busy=0, no conv_done; display dark until a new update completes.
